// File: rtl/word_packer_if.sv
// Word-packer data channels: narrow input words upstream, packed words plus lane mask downstream.
// valid/ready rule: a transfer happens on a rising edge where both valid and ready are high.
interface word_packer_if #(
   parameter int InW   = 16,
   parameter int Ratio = 4
);
   localparam int OutW = InW * Ratio;

   logic            in_valid_i;
   logic            in_ready_o;
   logic [InW-1:0]  in_data_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [OutW-1:0] out_data_o;
   logic [Ratio-1:0] out_mask_o;

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_mask_o
   );

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_mask_o
   );
endinterface

// File: rtl/word_packer.sv
// Packs Ratio narrow words into one wide word, lane 0 first; flush_i emits a
// partial group with a lane mask, clr_i drops all packing state.
module word_packer #(
   parameter int InW   = 16,
   parameter int Ratio = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic flush_i,
   output logic busy_o,
   word_packer_if.slave bus
);
   localparam int OutW = InW * Ratio;
   localparam int CntW = $clog2(Ratio + 1);

   logic [CntW-1:0]  acc_cnt;
   logic [OutW-1:0]  acc_q;
   logic             flush_pend;
   logic             out_valid_q;
   logic [OutW-1:0]  out_data_q;
   logic [Ratio-1:0] out_mask_q;

   logic             acc_last;
   logic             out_free;
   logic             in_ready;
   logic             in_fire;
   logic             complete;
   logic             flush_load;
   logic             flush_pend_d;
   logic [OutW-1:0]  acc_wr;
   logic [Ratio-1:0] part_mask;

   assign acc_last   = (acc_cnt == CntW'(Ratio - 1));
   assign out_free   = !out_valid_q || bus.out_ready_i;
   // Depends only on registers and control inputs, never on in_valid_i.
   assign in_ready   = !rst_i && !clr_i && !flush_pend &&
                       !(acc_last && out_valid_q && !bus.out_ready_i);
   assign in_fire    = bus.in_valid_i && in_ready;
   assign complete   = in_fire && acc_last;
   assign flush_load = flush_pend && (acc_cnt != '0) && out_free;

   always_comb begin
      acc_wr    = acc_q;
      part_mask = '0;
      for (int k = 0; k < Ratio; k++) begin
         if (CntW'(k) == acc_cnt) acc_wr[k*InW +: InW] = bus.in_data_i;
         part_mask[k] = (CntW'(k) < acc_cnt);
      end
   end

   // A pending flush retires when it has emitted the partial group or found nothing to emit.
   always_comb begin
      flush_pend_d = flush_pend;
      if (flush_pend) begin
         if (acc_cnt == '0 || flush_load) flush_pend_d = 1'b0;
      end else begin
         flush_pend_d = flush_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         acc_cnt     <= '0;
         acc_q       <= '0;
         flush_pend  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mask_q  <= '0;
      end else begin
         flush_pend <= flush_pend_d;
         if (complete) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_wr;
            out_mask_q  <= '1;
            acc_q       <= '0;
            acc_cnt     <= '0;
         end else if (flush_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q;
            out_mask_q  <= part_mask;
            acc_q       <= '0;
            acc_cnt     <= '0;
         end else begin
            if (out_valid_q && bus.out_ready_i) out_valid_q <= 1'b0;
            if (in_fire) begin
               acc_q   <= acc_wr;
               acc_cnt <= acc_cnt + CntW'(1);
            end
         end
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_mask_o  = out_mask_q;
   assign busy_o          = (acc_cnt != '0) || out_valid_q || flush_pend;
endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (InW=16, Ratio=4): packed words are queued as
// expected {mask,data} and popped by a monitor on every output transfer.
module tb_word_packer;
   localparam int InW   = 16;
   localparam int Ratio = 4;
   localparam int OutW  = InW * Ratio;
   localparam int ExpW  = OutW + Ratio;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic flush = 1'b0;
   logic busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [ExpW-1:0] exp_q[$];
   logic [ExpW-1:0] mon_exp;

   word_packer_if #(.InW(InW), .Ratio(Ratio)) bus ();

   word_packer #(.InW(InW), .Ratio(Ratio)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (clr),
      .flush_i(flush),
      .busy_o (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [ExpW-1:0] act, input logic [ExpW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until accepted; timeout counts as a failure.
   task automatic push(input logic [InW-1:0] d);
      int t;
      t = 0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = d;
      @(negedge clk);
      while (!bus.in_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout: got in_ready 0 expected 1 (word %h)", d);
      end
      step();
      bus.in_valid_i = 1'b0;
   endtask

   // Monitor: every output transfer outside reset/clear must match the queue head.
   always @(negedge clk) begin
      if (!rst && !clr && bus.out_valid_o && bus.out_ready_i) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got %h expected no output", {bus.out_mask_o, bus.out_data_o});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.out_mask_o, bus.out_data_o} !== mon_exp) begin
               n_err++;
               $display("FAIL out_word: got %h expected %h", {bus.out_mask_o, bus.out_data_o}, mon_exp);
            end
         end
      end
   end

   initial begin
      int t;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.out_ready_i = 1'b1;

      // Reset behaviour
      step(); step();
      chk("rst_in_ready", ExpW'(bus.in_ready_o), ExpW'(0));
      chk("rst_busy", ExpW'(busy), ExpW'(0));
      chk("rst_out_valid", ExpW'(bus.out_valid_o), ExpW'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", ExpW'(bus.in_ready_o), ExpW'(1));
      chk("rst_out_word", {bus.out_mask_o, bus.out_data_o}, ExpW'(0));

      // Full group back-to-back, one-cycle latency
      exp_q.push_back({4'hF, 64'h4444_3333_2222_1111});
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      chk("full_latency_valid", ExpW'(bus.out_valid_o), ExpW'(1));
      step();
      chk("full_idle_busy", ExpW'(busy), ExpW'(0));

      // Backpressure: group 1 held, words 5-7 accepted, word 8 stalled
      bus.out_ready_i = 1'b0;
      exp_q.push_back({4'hF, 64'h0004_0003_0002_0001});
      exp_q.push_back({4'hF, 64'h0008_0007_0006_0005});
      push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
      chk("bp_g1_valid", ExpW'(bus.out_valid_o), ExpW'(1));
      push(16'h0005); push(16'h0006); push(16'h0007);
      chk("bp_g1_stable", {bus.out_mask_o, bus.out_data_o}, {4'hF, 64'h0004_0003_0002_0001});
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 16'h0008;
      @(negedge clk);
      chk("bp_word8_stall", ExpW'(bus.in_ready_o), ExpW'(0));
      @(negedge clk);
      chk("bp_word8_stall2", ExpW'(bus.in_ready_o), ExpW'(0));
      chk("bp_g1_hold", {bus.out_mask_o, bus.out_data_o}, {4'hF, 64'h0004_0003_0002_0001});
      step();
      bus.out_ready_i = 1'b1;
      push(16'h0008);
      chk("bp_g2_valid", ExpW'(bus.out_valid_o), ExpW'(1));
      step();

      // Flush of a partial group
      exp_q.push_back({4'h3, 64'h0000_0000_BBBB_AAAA});
      push(16'hAAAA); push(16'hBBBB);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_in_ready_low", ExpW'(bus.in_ready_o), ExpW'(0));
      step();
      chk("flush_out_valid", ExpW'(bus.out_valid_o), ExpW'(1));
      chk("flush_in_ready_back", ExpW'(bus.in_ready_o), ExpW'(1));
      step();

      // Flush with empty accumulator
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("empty_flush_busy", ExpW'(busy), ExpW'(0));
      chk("empty_flush_valid", ExpW'(bus.out_valid_o), ExpW'(0));
      step();

      // Clear mid-group, then a fresh group
      push(16'h000A); push(16'h000B); push(16'h000C);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_busy", ExpW'(busy), ExpW'(0));
      exp_q.push_back({4'hF, 64'h0008_0007_0006_0005});
      push(16'h0005); push(16'h0006); push(16'h0007); push(16'h0008);
      chk("clr_group_valid", ExpW'(bus.out_valid_o), ExpW'(1));
      step();

      // Reset with a held output and two accumulated words
      bus.out_ready_i = 1'b0;
      push(16'h00D1); push(16'h00D2); push(16'h00D3); push(16'h00D4);
      push(16'h00E1); push(16'h00E2);
      chk("pre_rst_busy", ExpW'(busy), ExpW'(1));
      rst = 1'b1;
      step();
      chk("mid_rst_in_ready", ExpW'(bus.in_ready_o), ExpW'(0));
      chk("mid_rst_busy", ExpW'(busy), ExpW'(0));
      chk("mid_rst_out", {bus.out_valid_o, bus.out_mask_o, bus.out_data_o}, '0);
      rst = 1'b0;
      bus.out_ready_i = 1'b1;
      repeat (5) step();
      chk("post_rst_no_out", ExpW'(bus.out_valid_o), ExpW'(0));

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         step();
         t++;
      end
      chk("drain_queue", ExpW'(exp_q.size()), ExpW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
